// File: rtl/mrx_arbiter_if.sv
// -----------------------------------------------------------------------------
// mrx_arbiter_if
// Bundle of the packet-side signals of mrx_arbiter: N receive channels
// (access/packet in, wait out) and one downstream emesh sink (access/packet
// out, wait in).
//   in_access  [N]     per-channel packet valid
//   in_packet  [N*PW]  per-channel packet, channel i = [i*PW +: PW]
//   in_wait    [N]     per-channel pushback, 1 = hold packet
//   access_out         output packet valid
//   packet_out [PW]    output packet
//   wait_in            downstream pushback
// Modports: slave = arbiter view, master = channels + sink view.
// -----------------------------------------------------------------------------
interface mrx_arbiter_if #(
    parameter int N  = 4,
    parameter int PW = 104
);
    logic [N-1:0]    in_access;
    logic [N*PW-1:0] in_packet;
    logic [N-1:0]    in_wait;
    logic            access_out;
    logic [PW-1:0]   packet_out;
    logic            wait_in;

    modport slave (
        input  in_access, in_packet, wait_in,
        output in_wait, access_out, packet_out
    );

    modport master (
        output in_access, in_packet, wait_in,
        input  in_wait, access_out, packet_out
    );
endinterface

// File: rtl/mrx_arbiter.sv
// -----------------------------------------------------------------------------
// mrx_arbiter
// Round-robin arbiter sharing one emesh packet sink among N MIO receive
// channels, with a registered output stage.
// Ports:
//   clk    core clock, rising edge
//   reset  synchronous, active-high
//   bus    mrx_arbiter_if.slave (channel access/packet/wait, sink
//          access_out/packet_out/wait_in)
// Parameters: N (2..8) channels, PW packet width, BURST (1..15) max
// consecutive grants to one channel.
// Optional feature macro: MRX_ARB_BURST_EN enables burst hold; when undefined
// the priority pointer advances past every winner and BURST is ignored.
// -----------------------------------------------------------------------------
module mrx_arbiter #(
    parameter int N     = 4,
    parameter int PW    = 104,
    parameter int BURST = 4
) (
    input  logic           clk,
    input  logic           reset,
    mrx_arbiter_if.slave   bus
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    if (N < 2 || N > 8 || BURST < 1 || BURST > 15) begin : g_param_check
        $error("mrx_arbiter: N must be 2..8 and BURST 1..15");
    end

    logic [PTR_W-1:0] r_ptr;
    logic             r_access;
    logic [PW-1:0]    r_packet;

    logic             w_load;
    logic             w_gvld;
    logic [PTR_W-1:0] w_gidx;
    logic [PTR_W-1:0] w_inc;
    logic [N-1:0]     w_gnt;
    logic [PW-1:0]    w_gpkt;

    // Output register is free, or its packet leaves this cycle.
    assign w_load = ~r_access | ~bus.wait_in;

    // Rotating search: walk offsets from farthest to nearest so the requester
    // closest to r_ptr (in wrap order) is the last one written and wins.
    always_comb begin
        w_gvld = 1'b0;
        w_gidx = '0;
        for (int off = N - 1; off >= 0; off--) begin
            if (bus.in_access[(int'(r_ptr) + off) % N]) begin
                w_gvld = 1'b1;
                w_gidx = PTR_W'((int'(r_ptr) + off) % N);
            end
        end
        if (reset || !w_load) begin
            w_gvld = 1'b0;
        end
    end

    assign w_gnt  = w_gvld ? ({{(N-1){1'b0}}, 1'b1} << w_gidx) : '0;
    assign w_gpkt = bus.in_packet[int'(w_gidx)*PW +: PW];
    assign w_inc  = (w_gidx == PTR_W'(N - 1)) ? '0 : w_gidx + 1'b1;

    // Only the granted channel is released; everyone else holds.
    assign bus.in_wait    = ~w_gnt;
    assign bus.access_out = r_access;
    assign bus.packet_out = r_packet;

    // Output stage: load on grant, empty on an idle load, hold on stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_access <= 1'b0;
            r_packet <= '0;
        end else if (w_gvld) begin
            r_access <= 1'b1;
            r_packet <= w_gpkt;
        end else if (w_load) begin
            r_access <= 1'b0;
        end
    end

`ifdef MRX_ARB_BURST_EN
    localparam logic [3:0] BURST_L = 4'(BURST);

    logic [3:0]       r_bcnt;
    logic [PTR_W-1:0] r_last;
    logic [3:0]       w_bnew;

    // Length of the current run of grants to the same channel, including
    // this one. A completed burst clears the count so a repeat win starts a
    // fresh run.
    assign w_bnew = (w_gidx == r_last) ? r_bcnt + 4'd1 : 4'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr  <= '0;
            r_bcnt <= '0;
            r_last <= '0;
        end else if (w_gvld) begin
            r_last <= w_gidx;
            if (w_bnew >= BURST_L) begin
                r_bcnt <= '0;
                r_ptr  <= w_inc;
            end else begin
                // Pointer parks on the winner; if it stops requesting the
                // search naturally moves on to the next channel.
                r_bcnt <= w_bnew;
                r_ptr  <= w_gidx;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (w_gvld) begin
            r_ptr <= w_inc;
        end
    end
`endif

endmodule

// File: tb/tb_mrx_arbiter.sv
module tb_mrx_arbiter;
    localparam int N     = 4;
    localparam int PW    = 104;
    localparam int BURST = 4;

    logic clk;
    logic rst;

    mrx_arbiter_if #(.N(N), .PW(PW)) bus ();

    mrx_arbiter #(.N(N), .PW(PW), .BURST(BURST)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Stimulus state: what each channel is presenting.
    logic [N-1:0]  req;
    logic [PW-1:0] pk [N];
    logic [N-1:0]  keep;
    logic          wait_r;
    int            pkt_id = 0;

    // Reference model state (spec-level: rotating priority, one-slot output).
    int  m_ptr  = 0;
    int  m_run  = 0;
    int  m_last = 0;
    bit  m_full = 0;
    bit  primed = 0;
    bit  rst_prev = 0;
    int  last_g;
    logic [PW-1:0] sb [$];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] rand_pkt();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    function automatic logic [PW-1:0] new_pkt();
        pkt_id++;
        return PW'(64'hC0DE_0000_0000 + 64'(pkt_id));
    endfunction

    function automatic int model_grant();
        if (rst) return -1;
        if (m_full && wait_r) return -1;
        for (int off = 0; off < N; off++) begin
            if (req[(m_ptr + off) % N]) return (m_ptr + off) % N;
        end
        return -1;
    endfunction

    task automatic drive();
        bus.in_access = req;
        for (int i = 0; i < N; i++) bus.in_packet[i*PW +: PW] = pk[i];
        bus.wait_in = wait_r;
    endtask

    task automatic step(input bit rnd);
        int g;
        logic [N-1:0] exp_w;
        drive();
        #1;
        g = model_grant();
        exp_w = '1;
        if (g >= 0) exp_w[g] = 1'b0;
        last_g = -1;
        for (int i = 0; i < N; i++) if (bus.in_wait[i] === 1'b0) last_g = i;
        chk("in_wait", longint'(bus.in_wait), longint'(exp_w));
        if (primed) chk("access_out", longint'(bus.access_out), longint'(m_full));
        if (rst && rst_prev) begin
            chk("reset_access_out", longint'(bus.access_out), 0);
            chk("reset_packet_out_zero", longint'(bus.packet_out == '0), 1);
        end
        if (g >= 0) sb.push_back(pk[g]);
        rst_prev = rst;
        @(posedge clk);
        if (rst) primed = 1;
        if (rst) begin
            m_full = 0; m_ptr = 0; m_run = 0; m_last = 0;
            sb.delete();
        end else if (g >= 0) begin
            m_full = 1;
            m_run  = (g == m_last) ? m_run + 1 : 1;
            m_last = g;
`ifdef MRX_ARB_BURST_EN
            if (m_run >= BURST) begin
                m_ptr = (g + 1) % N;
                m_run = 0;
            end else begin
                m_ptr = g;
            end
`else
            m_ptr = (g + 1) % N;
`endif
        end else if (!m_full || !wait_r) begin
            m_full = 0;
        end
        #1;
        if (g >= 0) begin
            if (keep[g]) pk[g] = new_pkt();
            else req[g] = 1'b0;
        end
        if (rnd) begin
            wait_r = ($urandom % 4) == 0;
            for (int i = 0; i < N; i++) begin
                if (!req[i] && ($urandom % 2) == 1) begin
                    req[i] = 1'b1;
                    pk[i]  = rand_pkt();
                end
            end
            keep = N'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '1; keep = '1; wait_r = 1'b0;
        for (int i = 0; i < N; i++) pk[i] = new_pkt();
        repeat (3) step(0);
        rst = 1'b0; req = '0; keep = '0;
    endtask

    // Monitor: every transfer at the sink must match the oldest accepted packet.
    always @(negedge clk) begin
        if (!rst && bus.access_out === 1'b1 && bus.wait_in === 1'b0) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL extra_packet: got %h expected none", bus.packet_out);
            end else begin
                logic [PW-1:0] e;
                e = sb.pop_front();
                if (bus.packet_out !== e) begin
                    bad++;
                    $display("FAIL packet_out: got %h expected %h", bus.packet_out, e);
                end
            end
        end
    end

    initial begin
        logic [PW-1:0] held;
        int exp_rr [6];
        exp_rr = '{0, 1, 2, 3, 0, 1};

        rst = 1'b1; req = '1; keep = '1; wait_r = 1'b0;
        for (int i = 0; i < N; i++) pk[i] = new_pkt();
        drive();

        // Reset with every channel requesting.
        do_reset();

        // Single channel 2.
        req = 4'b0100; keep = '0; pk[2] = PW'(8'hA5);
        step(0);
        chk("single_grant", last_g, 2);
        chk("single_access_out", longint'(bus.access_out), 1);
        chk("single_packet_out", longint'(bus.packet_out[63:0]), 64'hA5);
        step(0);

        // Round-robin, all channels requesting continuously.
        do_reset();
        req = '1; keep = '1;
        for (int k = 0; k < 6; k++) begin
            step(0);
            chk("rr_order", last_g, exp_rr[k]);
        end
        req = '0;
        step(0);

`ifndef MRX_ARB_BURST_EN
        // Backpressure: output full, ch1/ch3 requesting, sink stalled.
        do_reset();
        req = 4'b0001; keep = '0;
        step(0);
        held = bus.packet_out;
        wait_r = 1'b1; req = 4'b1010;
        for (int k = 0; k < 5; k++) begin
            step(0);
            chk("stall_no_grant", last_g, -1);
            chk("stall_access_out", longint'(bus.access_out), 1);
            chk("stall_packet_held", longint'(bus.packet_out == held), 1);
        end
        wait_r = 1'b0;
        step(0);
        chk("release_grant_ch1", last_g, 1);
        step(0);
        chk("release_grant_ch3", last_g, 3);
        step(0);

        // Wrap-around then reset with output valid.
        do_reset();
        req = 4'b0100; keep = '0;
        step(0);
        req = 4'b1001;
        step(0);
        chk("wrap_grant_ch3", last_g, 3);
        step(0);
        chk("wrap_grant_ch0", last_g, 0);
        chk("wrap_access_out", longint'(bus.access_out), 1);
        rst = 1'b1; req = 4'b1111;
        step(0);
        chk("midreset_access_out", longint'(bus.access_out), 0);
        rst = 1'b0;
        step(0);
        chk("post_reset_ptr0", last_g, 0);
        req = '0;
        step(0);
`else
        // Burst hold: ch0 and ch1 continuous.
        begin
            int exp_b [9];
            exp_b = '{0, 0, 0, 0, 1, 1, 1, 1, 0};
            do_reset();
            req = 4'b0011; keep = 4'b0011;
            for (int k = 0; k < 9; k++) begin
                step(0);
                chk("burst_order", last_g, exp_b[k]);
            end
            req = '0;
            step(0);
            do_reset();
            req = 4'b0011; keep = 4'b0011;
            step(0);
            keep[0] = 1'b0;
            step(0);
            chk("burst_second_ch0", last_g, 0);
            step(0);
            chk("burst_drop_ch1", last_g, 1);
            req = '0;
            step(0);
        end
`endif

        // Randomised traffic.
        do_reset();
        for (int k = 0; k < 800; k++) step(1);

        // Drain and confirm nothing was lost.
        req = '0; wait_r = 1'b0;
        repeat (3) step(0);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
